// File: rtl/memarb_pkg.sv
// memarb_pkg: shared encodings for the membase port-A arbiter.
//   gnt_t   : owner of the current access (none / VGA / CPU / DMA)
//   state_t : access sequencer states (IDLE -> ISSUE -> WAIT -> ACK)
//   rr_other: the CPU/DMA requester that gets first pick after a grant
package memarb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VGA  = 2'd1,
        GNT_CPU  = 2'd2,
        GNT_DMA  = 2'd3
    } gnt_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    // After a CPU grant DMA is first in line, and vice versa.
    function automatic gnt_t rr_other(input gnt_t g);
        return (g == GNT_CPU) ? GNT_DMA : GNT_CPU;
    endfunction

endpackage

// File: rtl/memarb_pick.sv
// memarb_pick: combinational winner selection for mem_arbiter.
// Ports:
//   vga_req, cpu_req, dma_req : pending requests
//   rr_ptr                    : CPU/DMA side with first pick (GNT_CPU or GNT_DMA)
//   starved                   : VGA has used up its consecutive-grant allowance
//   winner                    : selected owner code, GNT_NONE when nothing pending
//   valid                     : a winner exists
module memarb_pick
    import memarb_pkg::*;
(
    input  logic vga_req,
    input  logic cpu_req,
    input  logic dma_req,
    input  gnt_t rr_ptr,
    input  logic starved,
    output gnt_t winner,
    output logic valid
);

    always_comb begin
        winner = GNT_NONE;
        if (vga_req && !starved)
            winner = GNT_VGA;
        else if (cpu_req && dma_req)
            winner = rr_ptr;
        else if (cpu_req)
            winner = GNT_CPU;
        else if (dma_req)
            winner = GNT_DMA;
        else if (vga_req)
            // Starve limit only matters while CPU/DMA wait; a lone VGA is served.
            winner = GNT_VGA;
        valid = (winner != GNT_NONE);
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares membase port A (8-bit, registered-address read) among
// VGA fetch, CPU and SD DMA. VGA has priority, capped by a starvation guard;
// CPU and DMA alternate round-robin. One access per IDLE->ISSUE->WAIT->ACK pass.
//
// Ports:
//   clock, reset                  : clock, synchronous active-high reset
//   vga_req/vga_addr/vga_ack      : VGA read channel
//   cpu_req/we/addr/wdata/ack     : CPU read/write channel
//   dma_req/we/addr/wdata/ack     : SD DMA read/write channel
//   rdata                         : read data, valid in the ack cycle
//   mem_address/mem_data/mem_wren : to membase port A
//   mem_q                         : from membase port A
//   busy                          : sequencer not idle
//   grant                         : owner of current access (0 none,1 VGA,2 CPU,3 DMA)
//   stat_vga/stat_cpu/stat_dma    : saturating grant counters
//
// Build option: define MEMARB_STATS_EN to synthesize the grant counters;
// otherwise stat_* are tied to zero.
module mem_arbiter
    import memarb_pkg::*;
#(
    parameter int ADDR_W     = 18,
    parameter int STARVE_MAX = 4,
    parameter int STAT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_wdata,
    output logic              dma_ack,
    output logic [7:0]        rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [7:0]        mem_data,
    output logic              mem_wren,
    input  logic [7:0]        mem_q,
    output logic              busy,
    output logic [1:0]        grant,
    output logic [STAT_W-1:0] stat_vga,
    output logic [STAT_W-1:0] stat_cpu,
    output logic [STAT_W-1:0] stat_dma
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    state_t            state, state_nx;
    gnt_t              owner, rr_ptr, winner;
    logic              win_valid, starved, take;
    logic [SC_W-1:0]   starve_cnt;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_data;
    logic              sel_we;

    assign starved = (starve_cnt >= SC_W'(STARVE_MAX));
    assign busy    = (state != S_IDLE);
    assign grant   = owner;
    // A new access is accepted only from IDLE; reqs are ignored elsewhere.
    assign take    = (state == S_IDLE) && win_valid;

    memarb_pick u_pick (
        .vga_req (vga_req),
        .cpu_req (cpu_req),
        .dma_req (dma_req),
        .rr_ptr  (rr_ptr),
        .starved (starved),
        .winner  (winner),
        .valid   (win_valid)
    );

    // Winner's address/data/we, latched once in IDLE so later changes are ignored.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_we   = 1'b0;
        case (winner)
            GNT_VGA: sel_addr = vga_addr;
            GNT_CPU: begin
                sel_addr = cpu_addr;
                sel_data = cpu_wdata;
                sel_we   = cpu_we;
            end
            GNT_DMA: begin
                sel_addr = dma_addr;
                sel_data = dma_wdata;
                sel_we   = dma_we;
            end
            default: ;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // FSM next state
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (win_valid) state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  state_nx = S_ACK;
            S_ACK:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Membase-side registers, acks and arbitration state
    always_ff @(posedge clock) begin
        if (reset) begin
            owner       <= GNT_NONE;
            rr_ptr      <= GNT_CPU;
            starve_cnt  <= '0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            rdata       <= '0;
            vga_ack     <= 1'b0;
            cpu_ack     <= 1'b0;
            dma_ack     <= 1'b0;
        end else begin
            vga_ack <= 1'b0;
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (take) begin
                        owner       <= winner;
                        mem_address <= sel_addr;
                        mem_data    <= sel_data;
                        mem_wren    <= sel_we;
                        if (winner == GNT_VGA) begin
                            // Only VGA grants that hold off a waiting CPU/DMA count.
                            if (cpu_req || dma_req) begin
                                if (!starved)
                                    starve_cnt <= starve_cnt + SC_W'(1);
                            end else begin
                                starve_cnt <= '0;
                            end
                        end else begin
                            starve_cnt <= '0;
                            rr_ptr     <= rr_other(winner);
                        end
                    end
                end
                S_ISSUE: mem_wren <= 1'b0;
                S_WAIT: begin
                    rdata   <= mem_q;
                    vga_ack <= (owner == GNT_VGA);
                    cpu_ack <= (owner == GNT_CPU);
                    dma_ack <= (owner == GNT_DMA);
                end
                S_ACK: owner <= GNT_NONE;
                default: ;
            endcase
        end
    end

`ifdef MEMARB_STATS_EN
    logic [STAT_W-1:0] cnt_vga, cnt_cpu, cnt_dma;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_vga <= '0;
            cnt_cpu <= '0;
            cnt_dma <= '0;
        end else if (take) begin
            case (winner)
                GNT_VGA: if (cnt_vga != '1) cnt_vga <= cnt_vga + STAT_W'(1);
                GNT_CPU: if (cnt_cpu != '1) cnt_cpu <= cnt_cpu + STAT_W'(1);
                GNT_DMA: if (cnt_dma != '1) cnt_dma <= cnt_dma + STAT_W'(1);
                default: ;
            endcase
        end
    end

    assign stat_vga = cnt_vga;
    assign stat_cpu = cnt_cpu;
    assign stat_dma = cnt_dma;
`else
    assign stat_vga = '0;
    assign stat_cpu = '0;
    assign stat_dma = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a behavioural
// membase model (registered read address, write on mem_wren).
module tb_mem_arbiter;
    localparam int ADDR_W     = 18;
    localparam int STARVE_MAX = 4;
    localparam int STAT_W     = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              vga_req, vga_ack;
    logic [ADDR_W-1:0] vga_addr;
    logic              cpu_req, cpu_we, cpu_ack;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              dma_req, dma_we, dma_ack;
    logic [ADDR_W-1:0] dma_addr;
    logic [7:0]        dma_wdata;
    logic [7:0]        rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [7:0]        mem_data;
    logic              mem_wren;
    logic [7:0]        mem_q;
    logic              busy;
    logic [1:0]        grant;
    logic [STAT_W-1:0] stat_vga, stat_cpu, stat_dma;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX), .STAT_W(STAT_W)) dut (
        .clock(clock), .reset(reset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_ack(dma_ack),
        .rdata(rdata), .mem_address(mem_address), .mem_data(mem_data),
        .mem_wren(mem_wren), .mem_q(mem_q), .busy(busy), .grant(grant),
        .stat_vga(stat_vga), .stat_cpu(stat_cpu), .stat_dma(stat_dma)
    );

    // membase model: address registered at the edge, q follows one cycle later
    logic [7:0]        ram [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] q_addr;
    always @(posedge clock) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        q_addr <= mem_address;
    end
    assign mem_q = ram[q_addr];

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0] who;
        logic       chk;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [1:0]        who;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        wdata;
        logic [7:0]        exp;
        logic              chk;
    } vec_t;
    vec_t vecs [0:9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ack_of(input logic [1:0] w);
        case (w)
            2'd1:    return vga_ack;
            2'd2:    return cpu_ack;
            default: return dma_ack;
        endcase
    endfunction

    task automatic drive(input logic [1:0] w, input logic r, input logic we,
                         input logic [ADDR_W-1:0] a, input logic [7:0] d);
        case (w)
            2'd1: begin vga_req = r; vga_addr = a; end
            2'd2: begin cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
            default: begin dma_req = r; dma_we = we; dma_addr = a; dma_wdata = d; end
        endcase
    endtask

    // Scoreboard consumer: every ack pops one expected {owner, rdata}.
    always @(negedge clock) begin : monitor
        exp_t       e;
        logic [1:0] w;
        if (vga_ack || cpu_ack || dma_ack) begin
            w = vga_ack ? 2'd1 : (cpu_ack ? 2'd2 : 2'd3);
            check("ack_onehot", $countones({vga_ack, cpu_ack, dma_ack}), 1);
            if (sb.size() == 0) begin
                check("unexpected_ack", {30'd0, w}, 0);
            end else begin
                e = sb.pop_front();
                check("ack_owner", {30'd0, w}, {30'd0, e.who});
                if (e.chk) check("rdata", {24'd0, rdata}, {24'd0, e.data});
            end
        end
    end

    // Lone access. Req is raised just after an edge, so the sampling edge is
    // the next one: mem_wren is visible at the 2nd negedge, the ack at the 4th.
    task automatic do_access(input string name, input logic [1:0] w, input logic we,
                             input logic [ADDR_W-1:0] a, input logic [7:0] d,
                             input logic [7:0] exp, input logic chk);
        int         n;
        logic [3:0] wm;
        logic       got;
        sb.push_back('{who: w, chk: chk & !we, data: exp});
        @(posedge clock); #1;
        drive(w, 1'b1, we, a, d);
        n = 0; wm = '0; got = 1'b0;
        while (!got && n < 16) begin
            @(negedge clock);
            n++;
            if (n <= 4) wm[n-1] = mem_wren;
            got = ack_of(w);
        end
        check({name, "_lat"}, n, 4);
        check({name, "_wren"}, {28'd0, wm}, we ? 32'h2 : 32'h0);
        @(posedge clock); #1;
        drive(w, 1'b0, 1'b0, a, d);
        if (!got) sb.delete();
    endtask

    task automatic wait_sb(input string name, input int budget);
        int cyc;
        cyc = 0;
        while (sb.size() != 0 && cyc < budget) begin
            @(posedge clock);
            cyc++;
        end
        if (sb.size() != 0) begin
            check({name, "_timeout"}, sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = i[7:0] ^ 8'hC3;
        q_addr = '0;

        // who, we, addr, wdata, expected rdata, check rdata
        vecs[0] = '{2'd2, 1'b1, 18'h00123, 8'h5A, 8'h00, 1'b0};
        vecs[1] = '{2'd2, 1'b0, 18'h00123, 8'h00, 8'h5A, 1'b1};
        vecs[2] = '{2'd3, 1'b1, 18'h3FFFF, 8'hA5, 8'h00, 1'b0};
        vecs[3] = '{2'd3, 1'b0, 18'h3FFFF, 8'h00, 8'hA5, 1'b1};
        vecs[4] = '{2'd1, 1'b0, 18'h00123, 8'h00, 8'h5A, 1'b1};
        vecs[5] = '{2'd1, 1'b0, 18'h00040, 8'h00, 8'h83, 1'b1};
        vecs[6] = '{2'd2, 1'b1, 18'h00200, 8'h77, 8'h00, 1'b0};
        vecs[7] = '{2'd3, 1'b1, 18'h00300, 8'h11, 8'h00, 1'b0};
        vecs[8] = '{2'd2, 1'b0, 18'h00000, 8'h00, 8'hC3, 1'b1};
        vecs[9] = '{2'd3, 1'b0, 18'h00300, 8'h00, 8'h11, 1'b1};

        reset = 1'b1;
        vga_req = 0; vga_addr = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_acks", {29'd0, vga_ack, cpu_ack, dma_ack}, 0);
        check("rst_rdata", {24'd0, rdata}, 0);
        check("rst_mem_address", {14'd0, mem_address}, 0);
        check("rst_mem_data_wren", {23'd0, mem_data, mem_wren}, 0);
        check("rst_busy_grant", {29'd0, busy, grant}, 0);
        check("rst_stats", {stat_vga, stat_cpu} | {16'd0, stat_dma}, 0);
        @(posedge clock); #1;
        reset = 1'b0;

        // lone accesses, including the CPU write/read pair and address extremes
        for (int i = 0; i < 10; i++)
            do_access($sformatf("vec%0d", i), vecs[i].who, vecs[i].we, vecs[i].addr,
                      vecs[i].wdata, vecs[i].exp, vecs[i].chk);

        // CPU and DMA held together: strict alternation starting with CPU
        for (int i = 0; i < 6; i++)
            sb.push_back('{who: (i % 2 == 0) ? 2'd2 : 2'd3, chk: 1'b0, data: 8'h00});
        @(posedge clock); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 18'h00010;
        dma_req = 1; dma_we = 0; dma_addr = 18'h00020;
        wait_sb("rr", 60);
        #1;
        cpu_req = 0; dma_req = 0;

        // VGA held with CPU: four VGA grants, then CPU, repeatedly
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < STARVE_MAX; i++)
                sb.push_back('{who: 2'd1, chk: 1'b0, data: 8'h00});
            sb.push_back('{who: 2'd2, chk: 1'b0, data: 8'h00});
        end
        @(posedge clock); #1;
        vga_req = 1; vga_addr = 18'h00400;
        cpu_req = 1; cpu_we = 0; cpu_addr = 18'h00010;
        wait_sb("starve", 100);
        #1;
        vga_req = 0; cpu_req = 0;

        // CPU address changed after the sampling edge: latched address is used
        sb.push_back('{who: 2'd2, chk: 1'b1, data: 8'h77});
        @(posedge clock); #1;
        drive(2'd2, 1'b1, 1'b0, 18'h00200, 8'h00);
        @(posedge clock); #1;
        cpu_addr = 18'h00300;
        wait_sb("addr_latch", 10);
        #1;
        cpu_req = 0;

        // reset while a DMA read is in WAIT: no ack, sequencer back to idle
        @(posedge clock); #1;
        drive(2'd3, 1'b1, 1'b0, 18'h00300, 8'h00);
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        dma_req = 0;
        @(negedge clock);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_grant", {30'd0, grant}, 0);
        check("midrst_rdata", {24'd0, rdata}, 0);
        repeat (4) begin
            @(negedge clock);
            check("midrst_no_ack", {29'd0, vga_ack, cpu_ack, dma_ack}, 0);
        end

        // after reset: 1 DMA, 3 VGA, 2 CPU grants
        do_access("post_rst_dma", 2'd3, 1'b0, 18'h00300, 8'h00, 8'h11, 1'b1);
        for (int i = 0; i < 3; i++)
            do_access($sformatf("st_vga%0d", i), 2'd1, 1'b0, 18'h00123, 8'h00, 8'h5A, 1'b1);
        for (int i = 0; i < 2; i++)
            do_access($sformatf("st_cpu%0d", i), 2'd2, 1'b0, 18'h3FFFF, 8'h00, 8'hA5, 1'b1);
        @(negedge clock);
`ifdef MEMARB_STATS_EN
        check("stat_vga", {16'd0, stat_vga}, 3);
        check("stat_cpu", {16'd0, stat_cpu}, 2);
        check("stat_dma", {16'd0, stat_dma}, 1);
`else
        check("stat_vga", {16'd0, stat_vga}, 0);
        check("stat_cpu", {16'd0, stat_cpu}, 0);
        check("stat_dma", {16'd0, stat_dma}, 0);
`endif
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
